twoff_tx_arbiter: RTL

TWOFF_TX_ARBITER -- requirements
Module: twoff_tx_arbiter

---
 rtl/twoff_tx_arbiter_pkg.sv | 13 +
 rtl/twoff_tx_arbiter_sync2.sv | 26 ++
 rtl/twoff_tx_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/twoff_tx_arbiter_pkg.sv
// twoff_tx_arbiter_pkg: shared definitions for the two-flop 4-phase transmit arbiter
// (state encodings and default data width).
package twoff_tx_arbiter_pkg;

    localparam int DATA_MSB = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_HI  = 2'd1,
        WAIT_LO = 2'd2
    } state_e;

endpackage

// File: rtl/twoff_tx_arbiter_sync2.sv
// twoff_tx_arbiter_sync2: two-flop synchronizer with synchronous reset.
module twoff_tx_arbiter_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/twoff_tx_arbiter.sv
// twoff_tx_arbiter: round-robin arbiter feeding one 4-phase req/ack channel into another
// clock domain; all outputs come straight from flops.
module twoff_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int DATA_MSB = twoff_tx_arbiter_pkg::DATA_MSB
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              src_valid,
    input  logic [NREQ*(DATA_MSB+1)-1:0] src_data,
    output logic [NREQ-1:0]              src_grant,
    output logic [NREQ-1:0]              src_done,
    output logic                         req,
    output logic [DATA_MSB:0]            data,
    input  logic                         ack,
    output logic                         busy
);

    import twoff_tx_arbiter_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = DATA_MSB + 1;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    state_e          state_q;
    logic            ack_s;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   win;
    logic            found;
    int              idx;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] done_q;
    logic            req_q;
    logic            busy_q;
    logic [DATA_MSB:0] data_q;

    twoff_tx_arbiter_sync2 #(.W(1)) u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (ack),
        .q     (ack_s)
    );

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_q) + i) % NREQ;
            if (!found && src_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            case (state_q)
                // A still-high ack_s is a leftover from the previous handshake; wait it out.
                IDLE: if (found && !ack_s) begin
                    data_q  <= src_data[int'(win)*DW +: DW];
                    grant_q <= ONE << win;
                    last_q  <= win;
                    req_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= REQ_HI;
                end
                REQ_HI: if (ack_s) begin
                    req_q   <= 1'b0;
                    state_q <= WAIT_LO;
                end
                WAIT_LO: if (!ack_s) begin
                    done_q  <= ONE << last_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign src_grant = grant_q;
    assign src_done  = done_q;
    assign req       = req_q;
    assign data      = data_q;
    assign busy      = busy_q;

endmodule
